// File: rtl/vector_exec_unit.sv
// Multi-cycle vector execution unit: latches one VV/VX/VI instruction and sweeps LANES
// elements per cycle over the active length, holding the packed result until accepted.
module vector_exec_unit #(
  parameter  int VECTOR_LENGTH = 8,
  parameter  int DATA_WIDTH    = 32,
  parameter  int LANES         = 2,
  localparam int VLW           = $clog2(VECTOR_LENGTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_a,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_b,
  input  logic [DATA_WIDTH-1:0]               scalar,
  input  logic [1:0]                          mode,
  input  logic [2:0]                          funct3,
  input  logic [VLW-1:0]                      vl,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [VECTOR_LENGTH*DATA_WIDTH-1:0] result,
  output logic                                err
);
  localparam int EW = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_p0 [VECTOR_LENGTH];
  logic [DATA_WIDTH-1:0]   b_p0 [VECTOR_LENGTH];
  logic [DATA_WIDTH-1:0]   scalar_p0;
  logic [1:0]              mode_p0;
  logic [2:0]              funct3_p0;
  logic [VLW-1:0]          vl_p0, beats_p0, beat_q;
  logic [DATA_WIDTH-1:0]   res_p1 [VECTOR_LENGTH];
  logic                    err_q;
  logic [VLW-1:0]          vl_c, beats_c;
  logic                    accept, last_beat;
  logic [EW-1:0]           lane_el  [LANES];
  logic                    lane_on  [LANES];
  logic signed [DATA_WIDTH-1:0] lane_res [LANES];

  function automatic logic signed [DATA_WIDTH-1:0] sel_b(
    input logic [1:0]            m,
    input logic [DATA_WIDTH-1:0] b_el,
    input logic [DATA_WIDTH-1:0] s
  );
    case (m)
      2'b00:   sel_b = $signed(b_el);
      2'b01:   sel_b = $signed(s);
      default: sel_b = $signed({{(DATA_WIDTH-5){s[4]}}, s[4:0]});
    endcase
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] alu(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b,
    input logic [2:0]                   f
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    prod = a * b;
    case (f)
      3'b000:  alu = a + b;
      3'b001:  alu = a - b;
      3'b010:  alu = $signed(prod[DATA_WIDTH-1:0]);
      3'b011:  alu = a & b;
      3'b100:  alu = a | b;
      3'b101:  alu = a ^ b;
      3'b110:  alu = (a < b) ? a : b;
      default: alu = (a > b) ? a : b;
    endcase
  endfunction

  assign vl_c      = (vl > VLW'(VECTOR_LENGTH)) ? VLW'(VECTOR_LENGTH) : vl;
  assign beats_c   = VLW'((int'(vl_c) + LANES - 1) / LANES);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign err       = err_q;
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_q == (beats_p0 - VLW'(1)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = ((vl_c == '0) || (mode == 2'b11)) ? DONE : EXEC;
      EXEC: if (last_beat) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // p0: instruction latch, frozen from accept until the unit returns to IDLE
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < VECTOR_LENGTH; i++) begin
        a_p0[i] <= vector_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_p0[i] <= vector_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
      scalar_p0 <= scalar;
      mode_p0   <= mode;
      funct3_p0 <= funct3;
      vl_p0     <= vl_c;
      beats_p0  <= beats_c;
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_el[j]  = EW'(int'(beat_q) * LANES + j);
      lane_on[j]  = (int'(beat_q) * LANES + j) < int'(vl_p0);
      lane_res[j] = alu($signed(a_p0[lane_el[j]]),
                        sel_b(mode_p0, b_p0[lane_el[j]], scalar_p0), funct3_p0);
    end
  end

  // p1: result accumulation; the register is cleared on accept so tail elements read 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < VECTOR_LENGTH; i++) res_p1[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          beat_q <= '0;
          err_q  <= (mode == 2'b11);
          for (int i = 0; i < VECTOR_LENGTH; i++) res_p1[i] <= '0;
        end
        EXEC: begin
          beat_q <= beat_q + VLW'(1);
          for (int j = 0; j < LANES; j++)
            if (lane_on[j]) res_p1[lane_el[j]] <= lane_res[j];
        end
        DONE: if (out_ready) begin
          beat_q <= '0;
          err_q  <= 1'b0;
        end
        default: beat_q <= '0;
      endcase
    end
  end

  for (genvar g = 0; g < VECTOR_LENGTH; g++) begin : g_pack
    assign result[g*DATA_WIDTH +: DATA_WIDTH] = res_p1[g];
  end
endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit: hand-computed vectors, latency, edge cases,
// backpressure and mid-instruction reset.
module tb_vector_exec_unit;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] vector_a;
  logic [255:0] vector_b;
  logic [31:0]  scalar;
  logic [1:0]   mode;
  logic [2:0]   funct3;
  logic [3:0]   vl;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] result;
  logic         err;

  int total = 0;
  int bad   = 0;
  int lat;
  logic [255:0] exp_r;
  logic [255:0] zero256;

  vector_exec_unit #(.VECTOR_LENGTH(8), .DATA_WIDTH(32), .LANES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .vector_a(vector_a), .vector_b(vector_b), .scalar(scalar), .mode(mode),
    .funct3(funct3), .vl(vl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [2:0] f, input logic [3:0] l,
                       input logic [31:0] s);
    mode = m; funct3 = f; vl = l; scalar = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) begin
      vector_a[i*32 +: 32] = 32'(i + 1);
      vector_b[i*32 +: 32] = 32'(i + 10);
    end
  endtask

  initial begin
    zero256 = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    vector_a = '0; vector_b = '0; scalar = '0; mode = '0; funct3 = '0; vl = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_result", result, zero256);
    rst = 1'b0;
    @(posedge clk); #1;

    // VV add, full length
    load_ramp();
    for (int i = 0; i < 8; i++) exp_r[i*32 +: 32] = 32'(2*i + 11);
    issue(2'b00, 3'b000, 4'd8, 32'd0);
    check("vv_add_busy", 256'(in_ready), 256'(0));
    wait_done(lat);
    check("vv_add_lat", 256'(lat), 256'(4));
    check("vv_add_res", result, exp_r);
    check("vv_add_err", 256'(err), 256'(0));
    check("vv_add_done_busy", 256'(in_ready), 256'(0));
    handshake();
    check("vv_add_release", 256'(out_valid), 256'(0));
    check("vv_add_idle", 256'(in_ready), 256'(1));

    // VX sub wraps below zero
    for (int i = 0; i < 8; i++) vector_a[i*32 +: 32] = 32'd5;
    for (int i = 0; i < 8; i++) exp_r[i*32 +: 32] = 32'hFFFF_FFFE;
    issue(2'b01, 3'b001, 4'd8, 32'd7);
    wait_done(lat);
    check("vx_sub_lat", 256'(lat), 256'(4));
    check("vx_sub_res", result, exp_r);
    handshake();

    // VI and with negative immediate, partial last beat, zero tail
    for (int i = 0; i < 8; i++) vector_a[i*32 +: 32] = 32'h1234_567F;
    exp_r = '0;
    for (int i = 0; i < 3; i++) exp_r[i*32 +: 32] = 32'h1234_5670;
    issue(2'b10, 3'b011, 4'd3, 32'h0000_0010);
    wait_done(lat);
    check("vi_and_lat", 256'(lat), 256'(2));
    check("vi_and_res", result, exp_r);
    handshake();

    // signed min / max on the most negative value
    vector_a = '0; vector_b = '0;
    vector_a[31:0] = 32'h8000_0000; vector_b[31:0] = 32'd1;
    exp_r = '0; exp_r[31:0] = 32'h8000_0000;
    issue(2'b00, 3'b110, 4'd1, 32'd0);
    wait_done(lat);
    check("min_lat", 256'(lat), 256'(1));
    check("min_res", result, exp_r);
    handshake();
    exp_r = '0; exp_r[31:0] = 32'd1;
    issue(2'b00, 3'b111, 4'd1, 32'd0);
    wait_done(lat);
    check("max_res", result, exp_r);
    handshake();

    // mul keeps only the low word
    vector_a[31:0] = 32'h0001_0000; vector_b[31:0] = 32'h0001_0000;
    issue(2'b00, 3'b010, 4'd1, 32'd0);
    wait_done(lat);
    check("mul_wrap_res", result, zero256);
    handshake();
    load_ramp();
    exp_r = '0;
    exp_r[31:0] = 32'hFFFF_FFFE; exp_r[63:32] = 32'hFFFF_FFFC;
    exp_r[95:64] = 32'hFFFF_FFFA; exp_r[127:96] = 32'hFFFF_FFF8;
    issue(2'b01, 3'b010, 4'd4, 32'hFFFF_FFFE);
    wait_done(lat);
    check("mul_neg_lat", 256'(lat), 256'(2));
    check("mul_neg_res", result, exp_r);
    handshake();

    // illegal mode completes immediately with err
    issue(2'b11, 3'b000, 4'd8, 32'd0);
    wait_done(lat);
    check("ill_lat", 256'(lat), 256'(0));
    check("ill_err", 256'(err), 256'(1));
    check("ill_res", result, zero256);
    handshake();
    check("ill_err_clear", 256'(err), 256'(0));

    // vl == 0
    issue(2'b00, 3'b000, 4'd0, 32'd0);
    wait_done(lat);
    check("vl0_lat", 256'(lat), 256'(0));
    check("vl0_res", result, zero256);
    check("vl0_err", 256'(err), 256'(0));
    handshake();

    // vl above the maximum clamps
    for (int i = 0; i < 8; i++) exp_r[i*32 +: 32] = 32'(2*i + 11);
    issue(2'b00, 3'b000, 4'd15, 32'd0);
    wait_done(lat);
    check("vl15_lat", 256'(lat), 256'(4));
    check("vl15_res", result, exp_r);
    handshake();

    // backpressure: DONE holds while a new instruction is offered
    for (int i = 0; i < 8; i++) vector_a[i*32 +: 32] = 32'(i);
    for (int i = 0; i < 8; i++) exp_r[i*32 +: 32] = 32'(i) ^ 32'hFF;
    issue(2'b01, 3'b101, 4'd8, 32'h0000_00FF);
    wait_done(lat);
    check("bp_lat", 256'(lat), 256'(4));
    mode = 2'b00; funct3 = 3'b000; vl = 4'd8; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 256'(out_valid), 256'(1));
      check("bp_res", result, exp_r);
      check("bp_busy", 256'(in_ready), 256'(0));
    end
    in_valid = 1'b0;
    handshake();
    check("bp_release", 256'(out_valid), 256'(0));

    // reset during the third beat abandons the instruction
    load_ramp();
    issue(2'b00, 3'b000, 4'd8, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("mid_rst_valid", 256'(out_valid), 256'(0));
    check("mid_rst_res", result, zero256);
    check("mid_rst_ready", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) vector_a[i*32 +: 32] = 32'd5;
    for (int i = 0; i < 8; i++) exp_r[i*32 +: 32] = 32'hFFFF_FFFE;
    issue(2'b01, 3'b001, 4'd8, 32'd7);
    wait_done(lat);
    check("post_rst_lat", 256'(lat), 256'(4));
    check("post_rst_res", result, exp_r);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
